// File: rtl/starter_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/data datapath stage among NUM_REQ requesters.
// Optional macro STARTER_ARB_PRIO_EN makes requester 0 high priority (preempts other owners).
module starter_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int DUT_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          dut_data_in,
  output logic                       dut_valid_in,
  input  logic [DATA_W-1:0]          dut_data_out,
  input  logic                       dut_valid_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t             r_state, w_state_next;
  logic [ID_W-1:0]    r_rr_ptr, r_grant_id, w_owner, w_rr_next;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [DATA_W-1:0]  r_dut_data_in, w_owner_data;
  logic               r_dut_valid_in;
  logic               w_any_valid, w_owner_valid, w_xfer, w_last_beat, w_preempt, w_exit;
  logic               r_tag_vld [DUT_LAT];
  logic [ID_W-1:0]    r_tag_id  [DUT_LAT];

  // Scan downwards so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_any_valid = |req_valid;
    w_owner     = r_rr_ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      v_idx = ID_W'((int'(r_rr_ptr) + off) % NUM_REQ);
      if (req_valid[v_idx]) w_owner = v_idx;
    end
`ifdef STARTER_ARB_PRIO_EN
    if (req_valid[0]) w_owner = '0;
`endif
  end

  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_owner_valid = req_valid[i];
        w_owner_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef STARTER_ARB_PRIO_EN
  assign w_preempt = (r_grant_id != '0) && req_valid[0];
`else
  assign w_preempt = 1'b0;
`endif

  assign w_xfer      = (r_state == ST_BURST) && w_owner_valid;
  assign w_last_beat = w_xfer && (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_exit      = (r_state == ST_BURST) && (w_last_beat || !w_owner_valid || w_preempt);
  assign w_rr_next   = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_valid) w_state_next = ST_BURST;
      ST_BURST: if (w_exit)      w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_grant_id     <= '0;
      r_beat_cnt     <= '0;
      r_dut_data_in  <= '0;
      r_dut_valid_in <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_dut_valid_in <= w_xfer;
      if (r_state == ST_IDLE && w_any_valid) begin
        r_grant_id <= w_owner;
        r_beat_cnt <= '0;
      end
      if (w_xfer) begin
        r_beat_cnt    <= r_beat_cnt + 1'b1;
        r_dut_data_in <= w_owner_data;
      end
      if (w_exit) r_rr_ptr <= w_rr_next;
    end
  end

  // grant_id is stable while dut_valid_in is high, so it tags the beat entering the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DUT_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_id[i]  <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_dut_valid_in;
      r_tag_id[0]  <= r_grant_id;
      for (int i = 1; i < DUT_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign req_ready[gi] = (r_state == ST_BURST) && (r_grant_id == ID_W'(gi));
      assign rsp_valid[gi] = dut_valid_out && r_tag_vld[DUT_LAT-1] &&
                             (r_tag_id[DUT_LAT-1] == ID_W'(gi));
    end
  endgenerate

  assign rsp_data     = dut_data_out;
  assign dut_data_in  = r_dut_data_in;
  assign dut_valid_in = r_dut_valid_in;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == ST_BURST);

endmodule
